// File: rtl/pq_relax_pkg.sv
// Shared types and helpers for the priority-queue driven shortest-path unit.
package pq_relax_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_SEED,
    S_SETTLE,
    S_POP,
    S_WAIT_POP,
    S_ROW,
    S_EDGE,
    S_RELAX,
    S_DONE
  } state_e;

  localparam int MAX_DIST_WIDTH = 64;
  localparam logic [MAX_DIST_WIDTH-1:0] DIST_INF = '1;

  // Saturating add for a distance of 'width' bits carried in the widest container.
  function automatic logic [MAX_DIST_WIDTH-1:0] sat_add(
    input logic [MAX_DIST_WIDTH-1:0] a,
    input logic [MAX_DIST_WIDTH-1:0] b,
    input int                        width
  );
    logic [MAX_DIST_WIDTH:0]   sum;
    logic [MAX_DIST_WIDTH-1:0] inf;
    sum = {1'b0, a} + {1'b0, b};
    inf = DIST_INF >> (MAX_DIST_WIDTH - width);
    if (sum >= {1'b0, inf}) return inf;
    return sum[MAX_DIST_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/relax_dist_mem.sv
// Tentative-distance array: two asynchronous read ports and one synchronous write port.
module relax_dist_mem #(
  parameter int NODE_WIDTH = 8,
  parameter int DIST_WIDTH = 32,
  parameter int NUM_NODES  = 256
) (
  input  logic                  clk_in,
  input  logic [NODE_WIDTH-1:0] rd_a_addr_in,
  output logic [DIST_WIDTH-1:0] rd_a_data_out,
  input  logic [NODE_WIDTH-1:0] rd_b_addr_in,
  output logic [DIST_WIDTH-1:0] rd_b_data_out,
  input  logic                  we_in,
  input  logic [NODE_WIDTH-1:0] wr_addr_in,
  input  logic [DIST_WIDTH-1:0] wr_data_in
);

  logic [DIST_WIDTH-1:0] mem_q [NUM_NODES];

  always_ff @(posedge clk_in) begin
    if (we_in) mem_q[wr_addr_in] <= wr_data_in;
  end

  assign rd_a_data_out = mem_q[rd_a_addr_in];
  assign rd_b_data_out = mem_q[rd_b_addr_in];

endmodule

// File: rtl/pq_relax_unit.sv
// Dijkstra relaxation controller closing the loop around an external priority queue.
// Optional statistics counters are built when PQ_RELAX_STATS_EN is defined.
module pq_relax_unit
  import pq_relax_pkg::*;
#(
  parameter int NODE_WIDTH      = 8,
  parameter int DIST_WIDTH      = 32,
  parameter int NUM_NODES       = 256,
  parameter int EDGE_ADDR_WIDTH = 12,
  parameter int MEM_LATENCY     = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       start_in,
  input  logic [NODE_WIDTH-1:0]      src_node_in,
  output logic                       busy_out,
  output logic                       done_out,
  output logic                       pq_deq_out,
  input  logic                       pq_valid_in,
  input  logic [NODE_WIDTH-1:0]      pq_data_in,
  input  logic [DIST_WIDTH-1:0]      pq_tag_in,
  input  logic                       pq_empty_in,
  input  logic                       pq_full_in,
  output logic                       pq_enq_out,
  output logic [NODE_WIDTH-1:0]      pq_enq_data_out,
  output logic [DIST_WIDTH-1:0]      pq_enq_tag_out,
  output logic [NODE_WIDTH-1:0]      row_addr_out,
  input  logic [EDGE_ADDR_WIDTH-1:0] row_start_in,
  input  logic [EDGE_ADDR_WIDTH-1:0] row_end_in,
  output logic [EDGE_ADDR_WIDTH-1:0] edge_addr_out,
  input  logic [NODE_WIDTH-1:0]      edge_dst_in,
  input  logic [DIST_WIDTH-1:0]      edge_w_in,
  input  logic [NODE_WIDTH-1:0]      dist_rd_addr_in,
  output logic [DIST_WIDTH-1:0]      dist_rd_data_out,
  output logic [15:0]                stat_pops_out,
  output logic [15:0]                stat_relax_out,
  output logic [15:0]                stat_stale_out
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 2);
  localparam logic [DIST_WIDTH-1:0] INF = DIST_INF[DIST_WIDTH-1:0];
  localparam logic [NODE_WIDTH-1:0] LAST_NODE = NODE_WIDTH'(NUM_NODES - 1);

  state_e                     state_q, state_d;
  logic [NODE_WIDTH-1:0]      src_q, src_d, node_q, node_d, init_q, init_d;
  logic [DIST_WIDTH-1:0]      du_q, du_d;
  logic [EDGE_ADDR_WIDTH-1:0] idx_q, idx_d, end_q, end_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  logic                  mem_we, advance, improve;
  logic [NODE_WIDTH-1:0] mem_waddr, mem_raddr;
  logic [DIST_WIDTH-1:0] mem_wdata, mem_rdata, nd;
  logic                  pop_evt, relax_evt, stale_evt, start_evt;

  relax_dist_mem #(
    .NODE_WIDTH(NODE_WIDTH), .DIST_WIDTH(DIST_WIDTH), .NUM_NODES(NUM_NODES)
  ) u_dist_mem (
    .clk_in(clk_in),
    .rd_a_addr_in(mem_raddr), .rd_a_data_out(mem_rdata),
    .rd_b_addr_in(dist_rd_addr_in), .rd_b_data_out(dist_rd_data_out),
    .we_in(mem_we), .wr_addr_in(mem_waddr), .wr_data_in(mem_wdata)
  );

  // dist[node] is latched at pop time so the single FSM read port can serve dist[dst].
  assign nd = DIST_WIDTH'(sat_add(MAX_DIST_WIDTH'(du_q), MAX_DIST_WIDTH'(edge_w_in), DIST_WIDTH));
  assign improve = (nd != INF) && (nd < mem_rdata);

  assign busy_out      = (state_q != S_IDLE);
  assign done_out      = (state_q == S_DONE);
  assign row_addr_out  = node_q;
  assign edge_addr_out = idx_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      node_q  <= '0;
      init_q  <= '0;
      du_q    <= '0;
      idx_q   <= '0;
      end_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      node_q  <= node_d;
      init_q  <= init_d;
      du_q    <= du_d;
      idx_q   <= idx_d;
      end_q   <= end_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    src_d           = src_q;
    node_d          = node_q;
    init_d          = init_q;
    du_d            = du_q;
    idx_d           = idx_q;
    end_d           = end_q;
    cnt_d           = '0;
    mem_we          = 1'b0;
    mem_waddr       = init_q;
    mem_wdata       = INF;
    mem_raddr       = edge_dst_in;
    advance         = 1'b0;
    pq_deq_out      = 1'b0;
    pq_enq_out      = 1'b0;
    pq_enq_data_out = '0;
    pq_enq_tag_out  = '0;
    pop_evt         = 1'b0;
    relax_evt       = 1'b0;
    stale_evt       = 1'b0;
    start_evt       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          state_d   = S_INIT;
          src_d     = src_node_in;
          init_d    = '0;
          start_evt = 1'b1;
        end
      end
      S_INIT: begin
        mem_we = 1'b1;
        init_d = init_q + 1'b1;
        if (init_q == LAST_NODE) state_d = S_SEED;
      end
      S_SEED: begin
        pq_enq_data_out = src_q;
        if (!pq_full_in) begin
          pq_enq_out = 1'b1;
          mem_we     = 1'b1;
          mem_waddr  = src_q;
          mem_wdata  = '0;
          state_d    = S_SETTLE;
        end
      end
      S_SETTLE: state_d = S_POP;
      S_POP: begin
        if (pq_empty_in) begin
          state_d = S_DONE;
        end else begin
          pq_deq_out = 1'b1;
          pop_evt    = 1'b1;
          state_d    = S_WAIT_POP;
        end
      end
      S_WAIT_POP: begin
        mem_raddr = pq_data_in;
        if (pq_valid_in) begin
          node_d = pq_data_in;
          du_d   = mem_rdata;
          if (pq_tag_in > mem_rdata) begin
            stale_evt = 1'b1;
            state_d   = S_POP;
          end else begin
            state_d = S_ROW;
          end
        end
      end
      S_ROW: begin
        if (cnt_q == CNT_W'(MEM_LATENCY)) begin
          idx_d   = row_start_in;
          end_d   = row_end_in;
          state_d = (row_start_in >= row_end_in) ? S_POP : S_EDGE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EDGE: begin
        if (cnt_q == CNT_W'(MEM_LATENCY)) state_d = S_RELAX;
        else cnt_d = cnt_q + 1'b1;
      end
      S_RELAX: begin
        pq_enq_data_out = edge_dst_in;
        pq_enq_tag_out  = nd;
        advance         = 1'b1;
        if (improve) begin
          if (pq_full_in) begin
            advance = 1'b0;
          end else begin
            pq_enq_out = 1'b1;
            mem_we     = 1'b1;
            mem_waddr  = edge_dst_in;
            mem_wdata  = nd;
            relax_evt  = 1'b1;
          end
        end
        if (advance) begin
          idx_d   = idx_q + 1'b1;
          state_d = ((idx_q + 1'b1) == end_q) ? S_SETTLE : S_EDGE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef PQ_RELAX_STATS_EN
  logic [15:0] pops_q, relax_q, stale_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pops_q  <= '0;
      relax_q <= '0;
      stale_q <= '0;
    end else if (start_evt) begin
      pops_q  <= '0;
      relax_q <= '0;
      stale_q <= '0;
    end else begin
      if (pop_evt && pops_q != 16'hFFFF)    pops_q  <= pops_q + 16'd1;
      if (relax_evt && relax_q != 16'hFFFF) relax_q <= relax_q + 16'd1;
      if (stale_evt && stale_q != 16'hFFFF) stale_q <= stale_q + 16'd1;
    end
  end

  assign stat_pops_out  = pops_q;
  assign stat_relax_out = relax_q;
  assign stat_stale_out = stale_q;
`else
  logic stats_unused;
  assign stats_unused   = ^{pop_evt, relax_evt, stale_evt, start_evt};
  assign stat_pops_out  = '0;
  assign stat_relax_out = '0;
  assign stat_stale_out = '0;
`endif

endmodule
